// File: rtl/mem_lock_arbiter.sv
// Grants exclusive single-port data RAM ownership to the oldest requesting memory SIC
// and muxes the owner's access onto the RAM port while the lock is held.
module mem_lock_arbiter #(
    parameter int unsigned NUM_SICS = 4,
    parameter int unsigned ID_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ID_WIDTH-1:0]          head_issue_id,
    input  logic [NUM_SICS-1:0]          req,
    input  logic [NUM_SICS*ID_WIDTH-1:0] req_issue_id,
    input  logic [NUM_SICS-1:0]          release_lock,
    input  logic [NUM_SICS*30-1:0]       sic_addr,
    input  logic [NUM_SICS*32-1:0]       sic_wdata,
    input  logic [NUM_SICS-1:0]          sic_wen,
    output logic [NUM_SICS-1:0]          mem_grant,
    output logic [31:0]                  mem_rdata,
    output logic [29:0]                  ram_addr,
    output logic [31:0]                  ram_wdata,
    output logic                         ram_wen,
    input  logic [31:0]                  ram_rdata,
    output logic                         busy
);

    localparam int unsigned IDX_W  = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   owner_nxt;
    logic               own_req;
    logic               own_rel;
    logic               found;
    logic [IDX_W-1:0]   best_idx;
    logic [ID_WIDTH-1:0] best_age;
    logic [ID_WIDTH-1:0] age;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Age-ordered arbitration and lock hold/release decision
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        own_req   = 1'b0;
        own_rel   = 1'b0;
        found     = 1'b0;
        best_idx  = '0;
        best_age  = '0;
        age       = '0;
        for (int i = 0; i < NUM_SICS; i++) begin
            // Modular distance from head makes wrap-around ordering correct
            age = ID_WIDTH'(req_issue_id[i*ID_WIDTH +: ID_WIDTH] - head_issue_id);
            if (req[i] && (!found || age < best_age)) begin
                found    = 1'b1;
                best_age = age;
                best_idx = IDX_W'(i);
            end
            if (owner == IDX_W'(i)) begin
                own_req = req[i];
                own_rel = release_lock[i];
            end
        end
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = LOCKED;
                    owner_nxt = best_idx;
                end
            end
            LOCKED: begin
                if (!own_req || own_rel) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Owner's access muxed onto the RAM port; everything quiet in reset or idle
    always_comb begin
        mem_grant = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wen   = 1'b0;
        busy      = 1'b0;
        if (!rst && state == LOCKED) begin
            busy = 1'b1;
            for (int i = 0; i < NUM_SICS; i++) begin
                if (owner == IDX_W'(i)) begin
                    mem_grant[i] = req[i];
                    ram_addr     = sic_addr[i*ADDR_W +: ADDR_W];
                    ram_wdata    = sic_wdata[i*DATA_W +: DATA_W];
                    ram_wen      = sic_wen[i] & req[i];
                end
            end
        end
    end

    assign mem_rdata = ram_rdata;

endmodule

// File: doc/mem_lock_arbiter.md
Name: mem_lock_arbiter

Overview:
- Sits directly upstream of every memory-executing SIC and downstream of them toward the single-port data RAM.
- Collects lock requests (req, req_issue_id, release_lock) from NUM_SICS memory SICs and grants exclusive RAM ownership to the oldest requester by issue age.
- Asserts that SIC's mem_grant every cycle while the lock is held.
- Muxes the owner's addr/wdata/wen onto the RAM port and broadcasts RAM read data back to all SICs.

Parameters:
- NUM_SICS, 4, number of requesting memory SICs (1..16)
- ID_WIDTH, 8, width of issue IDs; age arithmetic is modulo 2^ID_WIDTH
- IDX_W, $clog2(NUM_SICS) (min 1), owner index width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- head_issue_id  in  ID_WIDTH  issue ID of oldest in-flight instruction; age reference
- req  in  NUM_SICS  per-SIC lock request
- req_issue_id  in  NUM_SICS*ID_WIDTH  per-SIC issue ID; slice i = [i*ID_WIDTH +: ID_WIDTH]
- release_lock  in  NUM_SICS  per-SIC lock release
- sic_addr  in  NUM_SICS*30  per-SIC word address
- sic_wdata  in  NUM_SICS*32  per-SIC write data
- sic_wen  in  NUM_SICS  per-SIC write enable
- mem_grant  out  NUM_SICS  one-hot grant to lock owner
- mem_rdata  out  32  RAM read data, broadcast to all SICs
- ram_addr  out  30  RAM word address
- ram_wdata  out  32  RAM write data
- ram_wen  out  1  RAM write enable
- ram_rdata  in  32  RAM combinational read data for ram_addr
- busy  out  1  lock held (debug/perf)

Behaviour:
- State: `locked` (1 bit) and `owner` (IDX_W), both registered. States: IDLE (`locked`=0), LOCKED (`locked`=1).
- Reset values (any cycle with rst=1, including mid-lock): locked=0, owner=0.
- Outputs while rst=1 or IDLE: mem_grant=0, ram_wen=0, ram_addr=0, ram_wdata=0, busy=0.
- mem_rdata = ram_rdata at all times, combinational passthrough.
- Age: age_i = req_issue_id_i − head_issue_id, unsigned mod 2^ID_WIDTH. Smaller age is older. Correct across ID wrap-around.
- IDLE arbitration: among i with req[i]=1, pick minimal age_i. Ties go to the lowest index. If any req is set, register locked=1 and owner=winner at the edge.
- Latency: req asserted in cycle N (IDLE) gives mem_grant[owner]=1 in cycle N+1. No grant in the arbitration cycle itself.
- LOCKED, combinational:
  - mem_grant[owner] = req[owner]; all other grants are 0.
  - ram_addr = sic_addr[owner], ram_wdata = sic_wdata[owner].
  - ram_wen = sic_wen[owner] & req[owner].
- LOCKED, transitions (edge):
  - release_lock[owner]=1 → IDLE.
  - req[owner]=0 (abort) → IDLE, regardless of release.
  - Otherwise stay LOCKED. Holds are unbounded, so multi-cycle read-modify-write sequences are supported.
- After release, the next owner is chosen in the following IDLE cycle: one dead cycle between owners, no back-to-back handoff.
- Non-owner signals: release_lock and sic_wen from non-owners are ignored. Non-owner req only takes effect in IDLE arbitration.
- Owner issue ID is not re-checked while locked; no preemption by an older requester.
- Release in the same cycle as grant: the grant and write for that cycle still take effect (same-cycle release).
- busy = locked.

Test Plan:
- Single request: reset, head=0x00, req=4'b0010, id1=0x05, sic_addr1=0x100, wen=0 → cycle+1: mem_grant=4'b0010, ram_addr=0x100; release_lock1 that cycle → next cycle busy=0, grant=0.
- Age with wrap: head=0xFE, req=4'b1001, id0=0x01 (age 3), id3=0xFF (age 1) → owner=3. After release and req3 drop, SIC0 is granted after one IDLE cycle.
- Tie / lowest index: req=4'b0110 with id1=id2=0x10, head=0x10 → grant 4'b0010.
- Byte-store RMW hold: owner SIC2 holds req over 3 granted cycles (read, write with sic_wen2=1 and wdata=0xDEADBEEF, then release) → ram_wen=1 exactly in the 2nd granted cycle. Concurrent sic_wen0=1 from non-owner never reaches ram_wen.
- Abort: owner drops req without release_lock → grant deasserts the same cycle, busy=0 next cycle, ram_wen never asserted.
- Reset mid-lock: rst=1 while LOCKED with sic_wen=1 → in that cycle grant=0 and ram_wen=0; after rst falls, pending req is re-arbitrated with one-cycle grant latency.
